write_back_stage: RTL and testbench

- Final pipeline stage; consumes the memory-stage pipeline registers (ALU result, memory read data, LDM immediate, input-port sample, destination address, write/out enables).
- Selects the write-back value and drives the register-file write port.
- Owns the architectural output-port register.
- Keeps a one-entry history of the previous retired write and answers two forwarding lookups for the execute stage.

---
 rtl/write_back_stage.sv | 118 +++++++++++
 tb/tb_write_back_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/write_back_stage.sv
// Write-back stage: selects the retiring value, drives the GPR write port, owns the
// output-port register and a one-entry write history for execute-stage forwarding.
// Optional retire counter enabled by defining WB_RETIRE_COUNTER_EN.
module write_back_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [1:0]        wb_sel,
  input  logic [DATA_W-1:0] alu_value,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] ldm_value,
  input  logic [DATA_W-1:0] input_port,
  input  logic [ADDR_W-1:0] reg_write_address,
  input  logic              outport_enable,
  input  logic [DATA_W-1:0] out_src,
  input  logic              flush,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic [ADDR_W-1:0] src2_addr,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] out_port,
  output logic              out_strobe,
  output logic              fwd1_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd2_data,
  output logic [31:0]       retire_count
);

  logic [DATA_W-1:0] wb_value;
  logic              out_load;
  logic [DATA_W-1:0] out_port_q, out_port_d;
  logic              out_strobe_q;
  logic              hv_q;
  logic [ADDR_W-1:0] ha_q;
  logic [DATA_W-1:0] hd_q;

  always_comb begin
    wb_value = alu_value;
    case (wb_sel)
      2'b00:   wb_value = alu_value;
      2'b01:   wb_value = mem_data;
      2'b10:   wb_value = ldm_value;
      default: wb_value = input_port;
    endcase
  end

  assign rf_we    = reg_write & ~flush;
  assign rf_waddr = reg_write_address;
  assign rf_wdata = wb_value;

  assign out_load   = outport_enable & ~flush;
  assign out_port_d = out_load ? out_src : out_port_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_port_q   <= '0;
      out_strobe_q <= 1'b0;
      hv_q         <= 1'b0;
      ha_q         <= '0;
      hd_q         <= '0;
    end else begin
      out_port_q   <= out_port_d;
      out_strobe_q <= out_load;
      hv_q         <= rf_we;
      ha_q         <= rf_waddr;
      hd_q         <= rf_wdata;
    end
  end

  assign out_port   = out_port_q;
  assign out_strobe = out_strobe_q;

  // The write retiring this cycle is newer than history, so it is checked first.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    if (rf_we && (src1_addr == rf_waddr)) begin
      fwd1_hit  = 1'b1;
      fwd1_data = rf_wdata;
    end else if (hv_q && (src1_addr == ha_q)) begin
      fwd1_hit  = 1'b1;
      fwd1_data = hd_q;
    end
  end

  always_comb begin
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    if (rf_we && (src2_addr == rf_waddr)) begin
      fwd2_hit  = 1'b1;
      fwd2_data = rf_wdata;
    end else if (hv_q && (src2_addr == ha_q)) begin
      fwd2_hit  = 1'b1;
      fwd2_data = hd_q;
    end
  end

`ifdef WB_RETIRE_COUNTER_EN
  logic [31:0] retire_q, retire_d;

  assign retire_d = ((reg_write | outport_enable) & ~flush) ? retire_q + 32'd1 : retire_q;

  always_ff @(posedge clk) begin
    if (reset) retire_q <= '0;
    else       retire_q <= retire_d;
  end

  assign retire_count = retire_q;
`else
  assign retire_count = '0;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Bench for write_back_stage: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the stage.
module tb_write_back_stage;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset, reg_write, outport_enable, flush;
  logic [1:0]    wb_sel;
  logic [DW-1:0] alu_value, mem_data, ldm_value, input_port, out_src;
  logic [AW-1:0] reg_write_address, src1_addr, src2_addr;
  logic          rf_we, out_strobe, fwd1_hit, fwd2_hit;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata, out_port, fwd1_data, fwd2_data;
  logic [31:0]   retire_count;

  int compared = 0;
  int mismatched = 0;

  write_back_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_value(alu_value), .mem_data(mem_data), .ldm_value(ldm_value),
    .input_port(input_port), .reg_write_address(reg_write_address),
    .outport_enable(outport_enable), .out_src(out_src), .flush(flush),
    .src1_addr(src1_addr), .src2_addr(src2_addr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_port(out_port), .out_strobe(out_strobe),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          started = 0;
  bit [DW-1:0] m_out_port;
  bit          m_strobe;
  bit          m_hist_valid;
  bit [AW-1:0] m_hist_addr;
  bit [DW-1:0] m_hist_data;
  int unsigned m_count;

  function automatic bit [DW-1:0] pick_value();
    bit [DW-1:0] srcs [4];
    srcs[0] = alu_value; srcs[1] = mem_data; srcs[2] = ldm_value; srcs[3] = input_port;
    return srcs[wb_sel];
  endfunction

  function automatic bit writes_now();
    return reg_write && !flush;
  endfunction

  function automatic bit [DW+1-1:0] lookup(input bit [AW-1:0] src);
    if (writes_now() && src == reg_write_address) return {1'b1, pick_value()};
    if (m_hist_valid && src == m_hist_addr)        return {1'b1, m_hist_data};
    return '0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      started      = 1;
      m_out_port   = 0;
      m_strobe     = 0;
      m_hist_valid = 0;
      m_hist_addr  = 0;
      m_hist_data  = 0;
      m_count      = 0;
    end else begin
      m_hist_valid = writes_now();
      m_hist_addr  = reg_write_address;
      m_hist_data  = pick_value();
      m_strobe     = outport_enable && !flush;
      if (m_strobe) m_out_port = out_src;
      if ((reg_write || outport_enable) && !flush) m_count = m_count + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef WB_RETIRE_COUNTER_EN
    return m_count;
`else
    return 32'd0;
`endif
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      bit [DW:0] f1, f2;
      f1 = lookup(src1_addr);
      f2 = lookup(src2_addr);
      check("rf_we",      32'(rf_we),      32'(writes_now()));
      check("rf_waddr",   32'(rf_waddr),   32'(reg_write_address));
      check("rf_wdata",   32'(rf_wdata),   32'(pick_value()));
      check("out_port",   32'(out_port),   32'(m_out_port));
      check("out_strobe", 32'(out_strobe), 32'(m_strobe));
      check("fwd1_hit",   32'(fwd1_hit),   32'(f1[DW]));
      check("fwd1_data",  32'(fwd1_data),  32'(f1[DW-1:0]));
      check("fwd2_hit",   32'(fwd2_hit),   32'(f2[DW]));
      check("fwd2_data",  32'(fwd2_data),  32'(f2[DW-1:0]));
      check("retire_cnt", retire_count,    exp_count());
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; reg_write = 0; outport_enable = 0; flush = 0; wb_sel = 0;
    alu_value = 0; mem_data = 0; ldm_value = 0; input_port = 0; out_src = 0;
    reg_write_address = 0; src1_addr = 0; src2_addr = 0;
  endtask

  initial begin
    logic [DW-1:0] sweep_exp [4];
    sweep_exp[0] = 16'h1111; sweep_exp[1] = 16'h2222;
    sweep_exp[2] = 16'h3333; sweep_exp[3] = 16'h4444;

    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    check("rst_out_port", 32'(out_port), 32'h0);
    check("rst_strobe",   32'(out_strobe), 32'h0);
    check("rst_fwd1_hit", 32'(fwd1_hit), 32'h0);
    check("rst_count",    retire_count, 32'h0);

    // wb_sel sweep
    reg_write = 1; reg_write_address = 5;
    alu_value = 16'h1111; mem_data = 16'h2222; ldm_value = 16'h3333; input_port = 16'h4444;
    for (int i = 0; i < 4; i++) begin
      wb_sel = 2'(i);
      #1;
      check("sweep_wdata", 32'(rf_wdata), 32'(sweep_exp[i]));
      check("sweep_we",    32'(rf_we), 32'h1);
      check("sweep_waddr", 32'(rf_waddr), 32'h5);
      tick();
    end

    // OUT pulse
    idle();
    outport_enable = 1; out_src = 16'hBEEF;
    tick();
    outport_enable = 0;
    check("out_load",    32'(out_port), 32'hBEEF);
    check("out_strobe1", 32'(out_strobe), 32'h1);
    tick();
    check("out_strobe0", 32'(out_strobe), 32'h0);
    check("out_hold",    32'(out_port), 32'hBEEF);

    // flush beats both enables
    reg_write = 1; reg_write_address = 4; alu_value = 16'h7777;
    outport_enable = 1; out_src = 16'h1234; flush = 1;
    #1;
    check("flush_we", 32'(rf_we), 32'h0);
    tick();
    idle();
    src1_addr = 4;
    #1;
    check("flush_out_port", 32'(out_port), 32'hBEEF);
    check("flush_strobe",   32'(out_strobe), 32'h0);
    check("flush_fwd_miss", 32'(fwd1_hit), 32'h0);

    // current write beats history
    reg_write = 1; reg_write_address = 3; alu_value = 16'h00AA;
    tick();
    alu_value = 16'h00BB; src1_addr = 3; src2_addr = 3;
    #1;
    check("prio_hit1",  32'(fwd1_hit), 32'h1);
    check("prio_data1", 32'(fwd1_data), 32'h00BB);
    check("prio_hit2",  32'(fwd2_hit), 32'h1);
    check("prio_data2", 32'(fwd2_data), 32'h00BB);
    tick();
    reg_write = 0;
    #1;
    check("hist_hit",  32'(fwd1_hit), 32'h1);
    check("hist_data", 32'(fwd1_data), 32'h00BB);

    // history hit on one source, miss on the other
    reg_write = 1; reg_write_address = 2; alu_value = 16'h5555;
    tick();
    reg_write = 0; src1_addr = 2; src2_addr = 6;
    #1;
    check("hm_hit1",  32'(fwd1_hit), 32'h1);
    check("hm_data1", 32'(fwd1_data), 32'h5555);
    check("hm_hit2",  32'(fwd2_hit), 32'h0);
    check("hm_data2", 32'(fwd2_data), 32'h0);

    // counter and mid-run reset
    idle(); reset = 1; tick();
    reset = 0; reg_write = 1; reg_write_address = 1; alu_value = 16'h0101;
    tick(); tick(); tick();
    flush = 1; tick();
    idle(); src1_addr = 1;
    #1;
`ifdef WB_RETIRE_COUNTER_EN
    check("count3", retire_count, 32'd3);
`else
    check("count_tied", retire_count, 32'd0);
`endif
    reset = 1; out_src = 16'hFFFF; outport_enable = 1;
    tick();
    idle(); src1_addr = 1; src2_addr = 3;
    #1;
    check("rst2_count",   retire_count, 32'h0);
    check("rst2_outport", 32'(out_port), 32'h0);
    check("rst2_hit1",    32'(fwd1_hit), 32'h0);
    check("rst2_hit2",    32'(fwd2_hit), 32'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset             = ($urandom_range(0, 59) == 0);
      reg_write         = $urandom_range(0, 1);
      outport_enable    = ($urandom_range(0, 2) == 0);
      flush             = ($urandom_range(0, 4) == 0);
      wb_sel            = 2'($urandom_range(0, 3));
      alu_value         = 16'($urandom);
      mem_data          = 16'($urandom);
      ldm_value         = 16'($urandom);
      input_port        = 16'($urandom);
      out_src           = 16'($urandom);
      reg_write_address = 3'($urandom_range(0, 7));
      src1_addr         = 3'($urandom_range(0, 7));
      src2_addr         = 3'($urandom_range(0, 7));
      tick();
    end

    idle();
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
